// File: rtl/addsub_divider_sequencer_pkg.sv
// Shared types and constants for the restoring divider sequencer.
// Define DIV_SIGNED_EN to build the signed-capable variant.
package div_seq_pkg;

  localparam int WIDTH = 32;
  localparam int CALC_ITERS = 32;
  localparam logic [WIDTH-1:0] DIVZ_QUOTIENT = 32'hFFFFFFFF;

`ifdef DIV_SIGNED_EN
  typedef enum logic [2:0] {
    IDLE, ABS_DD, ABS_DS, CALC, FIX_Q, FIX_R, DONE
  } state_t;
`else
  typedef enum logic [1:0] {
    IDLE, CALC, DONE
  } state_t;
`endif

endpackage

// File: rtl/addsub_divider_sequencer_if.sv
// Request/response handshake bundle for the divider sequencer.
// Master is the requester, slave is the divider.
interface addsub_divider_sequencer_if;
  logic        start_valid;
  logic        start_ready;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic        is_signed;
  logic        res_valid;
  logic        res_ready;
  logic [31:0] quotient;
  logic [31:0] remainder;
  logic        div_by_zero;

  modport master (
    output start_valid, dividend, divisor,
    output is_signed, res_ready,
    input  start_ready, res_valid,
    input  quotient, remainder, div_by_zero
  );

  modport slave (
    input  start_valid, dividend, divisor,
    input  is_signed, res_ready,
    output start_ready, res_valid,
    output quotient, remainder, div_by_zero
  );
endinterface

// File: rtl/addsub_divider_sequencer_cla.sv
// 32-bit carry-lookahead add/sub core: sum = a + (b ^ s) + s.
// Eight 4-bit lookahead groups chained on group carries.
module addsub_divider_sequencer_cla (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        s,
  output logic [31:0] sum,
  output logic        cout
);
  logic [31:0] bx;
  logic [31:0] g;
  logic [31:0] p;
  logic [8:0]  gc;

  assign bx = b ^ {32{s}};
  assign g  = a & bx;
  assign p  = a ^ bx;
  assign gc[0] = s;

  for (genvar i = 0; i < 8; i++) begin : grp
    localparam int B = 4 * i;
    logic [3:0] c;
    assign c[0] = gc[i];
    assign c[1] = g[B]
                | (p[B] & gc[i]);
    assign c[2] = g[B+1]
                | (p[B+1] & g[B])
                | (&p[B+1:B] & gc[i]);
    assign c[3] = g[B+2]
                | (p[B+2] & g[B+1])
                | (&p[B+2:B+1] & g[B])
                | (&p[B+2:B] & gc[i]);
    assign gc[i+1] = g[B+3]
                   | (p[B+3] & g[B+2])
                   | (&p[B+3:B+2] & g[B+1])
                   | (&p[B+3:B+1] & g[B])
                   | (&p[B+3:B] & gc[i]);
    assign sum[B+3:B] = p[B+3:B] ^ c;
  end

  assign cout = gc[8];
endmodule

// File: rtl/addsub_divider_sequencer.sv
// Restoring 32-bit divider issuing one subtract per cycle to the CLA core.
// DIV_SIGNED_EN adds abs/fixup states for signed requests.
module addsub_divider_sequencer
  import div_seq_pkg::*;
(
  input  logic                         clk,
  input  logic                         rst,
  addsub_divider_sequencer_if.slave    bus
);
  state_t           state;
  logic [4:0]       cnt;
  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] qsh;
  logic [WIDTH-1:0] dsr;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             dbz;
  logic             res_valid;
`ifdef DIV_SIGNED_EN
  logic             sgn;
  logic             dd_neg;
  logic             ds_neg;
`endif

  logic [WIDTH-1:0] core_a;
  logic [WIDTH-1:0] core_b;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic [WIDTH-1:0] shifted;
  logic             qbit;
  logic [WIDTH-1:0] rem_nx;
  logic [WIDTH-1:0] qsh_nx;

  assign shifted = {rem[30:0], qsh[31]};
  assign qbit    = rem[31] | cout;
  assign rem_nx  = qbit ? sum : shifted;
  assign qsh_nx  = {qsh[30:0], qbit};

  // Operand mux: CALC trial-subtracts, fixup states negate (0 - x).
  always_comb begin
    core_a = '0;
    core_b = dsr;
    case (state)
      CALC: core_a = shifted;
`ifdef DIV_SIGNED_EN
      ABS_DD: core_b = qsh;
      FIX_Q:  core_b = qsh;
      FIX_R:  core_b = rem;
`endif
      default: core_b = dsr;
    endcase
  end

  addsub_divider_sequencer_cla u_core (
    .a    (core_a),
    .b    (core_b),
    .s    (1'b1),
    .sum  (sum),
    .cout (cout)
  );

  // Sequencer FSM with registered result outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      rem       <= '0;
      qsh       <= '0;
      dsr       <= '0;
      quotient  <= '0;
      remainder <= '0;
      dbz       <= 1'b0;
      res_valid <= 1'b0;
`ifdef DIV_SIGNED_EN
      sgn       <= 1'b0;
      dd_neg    <= 1'b0;
      ds_neg    <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (bus.start_valid) begin
            qsh <= bus.dividend;
            dsr <= bus.divisor;
            rem <= '0;
            cnt <= '0;
            dbz <= 1'b0;
`ifdef DIV_SIGNED_EN
            sgn    <= bus.is_signed;
            dd_neg <= bus.dividend[31];
            ds_neg <= bus.divisor[31];
            state  <= ABS_DD;
`else
            state  <= CALC;
`endif
          end
        end
`ifdef DIV_SIGNED_EN
        ABS_DD: begin
          if (dsr == '0) begin
            quotient  <= DIVZ_QUOTIENT;
            remainder <= qsh;
            dbz       <= 1'b1;
            res_valid <= 1'b1;
            state     <= DONE;
          end else begin
            if (sgn && dd_neg) qsh <= sum;
            state <= ABS_DS;
          end
        end
        ABS_DS: begin
          if (sgn && ds_neg) dsr <= sum;
          state <= CALC;
        end
        CALC: begin
          rem <= rem_nx;
          qsh <= qsh_nx;
          cnt <= cnt + 5'd1;
          if (cnt == 5'(CALC_ITERS - 1))
            state <= FIX_Q;
        end
        FIX_Q: begin
          if (sgn && (dd_neg ^ ds_neg)) qsh <= sum;
          state <= FIX_R;
        end
        FIX_R: begin
          quotient  <= qsh;
          remainder <= (sgn && dd_neg) ? sum : rem;
          res_valid <= 1'b1;
          state     <= DONE;
        end
`else
        CALC: begin
          if (cnt == 5'd0 && dsr == '0) begin
            quotient  <= DIVZ_QUOTIENT;
            remainder <= qsh;
            dbz       <= 1'b1;
            res_valid <= 1'b1;
            state     <= DONE;
          end else begin
            rem <= rem_nx;
            qsh <= qsh_nx;
            cnt <= cnt + 5'd1;
            if (cnt == 5'(CALC_ITERS - 1)) begin
              quotient  <= qsh_nx;
              remainder <= rem_nx;
              res_valid <= 1'b1;
              state     <= DONE;
            end
          end
        end
`endif
        DONE: begin
          if (bus.res_ready) begin
            res_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.start_ready = (state == IDLE) && !rst;
  assign bus.res_valid   = res_valid;
  assign bus.quotient    = quotient;
  assign bus.remainder   = remainder;
  assign bus.div_by_zero = dbz;
endmodule
